// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply,
// restoring shift-subtract divide, one iteration per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic                  we
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [W-1:0]        hi_q;
  logic [W-1:0]        lo_q;
  logic [W-1:0]        mc_q;
  logic                neg_q;
  logic [2:0]          f3_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                busy_q;
  logic                done_q;
  logic                we_q;
  logic [W-1:0]        result_q;
  logic [ADDR_WIDTH-1:0] rdo_q;

  // Operand conditioning at acceptance
  logic         a_sgn, b_sgn, a_neg, b_neg;
  logic         div0_d, ovf_d, neg_d;
  logic [W-1:0] a_abs, b_abs;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg  = a_sgn & op_a[W-1];
    b_neg  = b_sgn & op_b[W-1];
    a_abs  = a_neg ? -op_a : op_a;
    b_abs  = b_neg ? -op_b : op_b;
    div0_d = funct3[2] && (op_b == '0);
    ovf_d  = funct3[2] && !funct3[0] &&
             (op_a == MINV) && (op_b == '1);
    neg_d  = (funct3[2] && funct3[1]) ? a_neg
                                      : (a_neg ^ b_neg);
  end

  // One iteration of either core; hi/lo/mc are shared
  logic [W:0]   msum, dsh, ddif;
  logic         dok;
  logic [W-1:0] step_hi_d, step_lo_d;

  always_comb begin
    msum = {1'b0, hi_q} +
           ({1'b0, mc_q} & {(W+1){lo_q[0]}});
    dsh  = {hi_q, lo_q[W-1]};
    ddif = dsh - {1'b0, mc_q};
    dok  = !ddif[W];
    if (state_q == S_DIV) begin
      step_hi_d = dok ? ddif[W-1:0] : dsh[W-1:0];
      step_lo_d = {lo_q[W-2:0], dok};
    end else begin
      step_hi_d = msum[W:1];
      step_lo_d = {msum[0], lo_q[W-1:1]};
    end
  end

  // Sign fix-up and result select
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s, res_d;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = neg_q ? -hi_q : hi_q;
    res_d  = '0;
    unique case (1'b1)
      f3_q[2] && f3_q[1]:
        res_d = rem_s;
      f3_q[2] && !f3_q[1]:
        res_d = quo_s;
      !f3_q[2] && (f3_q[1:0] == 2'b00):
        res_d = prod_s[W-1:0];
      !f3_q[2] && (f3_q[1:0] != 2'b00):
        res_d = prod_s[2*W-1:W];
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      neg_q    <= 1'b0;
      f3_q     <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rdo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            cnt_q <= '0;
            neg_q <= neg_d;
            if (div0_d || ovf_d) begin
              // Answer preloaded as quotient/remainder pair
              hi_q    <= div0_d ? op_a : '0;
              lo_q    <= div0_d ? '1 : MINV;
              mc_q    <= '0;
              neg_q   <= 1'b0;
              state_q <= S_FIN;
            end else begin
              hi_q    <= '0;
              lo_q    <= funct3[2] ? a_abs : b_abs;
              mc_q    <= funct3[2] ? b_abs : a_abs;
              busy_q  <= 1'b1;
              state_q <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= step_hi_d;
            lo_q  <= step_lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          if (!flush) begin
            result_q <= res_d;
            rdo_q    <= rd_q;
            done_q   <= 1'b1;
            we_q     <= (rd_q != '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = we_q;
  assign result = result_q;
  assign rd_out = rdo_q;

endmodule
